// File: rtl/mem_port_arbiter.sv
// Fetch vs load/store arbiter for one single-port 16-bit memory.
// Load/store has priority; a starvation counter forces fetch through.
module mem_port_arbiter #(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_if_req,
    input  logic [15:0] i_if_addr,
    output logic        o_if_gnt,
    output logic        o_if_rvalid,
    output logic [15:0] o_if_rdata,
    input  logic        i_ls_rd,
    input  logic        i_ls_wr,
    input  logic [15:0] i_ls_addr,
    input  logic [15:0] i_ls_wrdata,
    output logic        o_ls_gnt,
    output logic        o_ls_rvalid,
    output logic [15:0] o_ls_rdata,
    output logic [15:0] o_mem_addr,
    output logic        o_mem_rd,
    output logic        o_mem_wr,
    output logic [15:0] o_mem_wrdata,
    input  logic [15:0] i_mem_rddata,
    input  logic        i_mem_waitreq,
    output logic        o_protocol_err
);

    logic                  stall;
    logic                  ls_req;
    logic                  force_if;
    logic                  if_gnt;
    logic                  ls_gnt;
    logic                  mem_acc;
    logic                  cmd_own_if;
    logic [3:0]            starve_cnt;
    logic [RD_LATENCY-1:0] tag_vld;
    logic [RD_LATENCY-1:0] tag_if;
    logic                  if_hit;
    logic                  ls_hit;
    logic [15:0]           if_rdata_q;
    logic [15:0]           ls_rdata_q;

    assign stall    = (o_mem_rd | o_mem_wr) & i_mem_waitreq;
    assign ls_req   = i_ls_rd | i_ls_wr;
    assign force_if = (starve_cnt >= 4'(STARVE_LIMIT)) & i_if_req;
    assign if_gnt   = ~reset & ~stall & (force_if | (i_if_req & ~ls_req));
    assign ls_gnt   = ~reset & ~stall & ~if_gnt & ls_req;
    assign mem_acc  = o_mem_rd & ~i_mem_waitreq;

    assign o_if_gnt       = if_gnt;
    assign o_ls_gnt       = ls_gnt;
    assign o_protocol_err = ~reset & i_ls_rd & i_ls_wr;

    // Command register; a simultaneous rd+wr is issued as a write only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_mem_addr   <= '0;
            o_mem_rd     <= 1'b0;
            o_mem_wr     <= 1'b0;
            o_mem_wrdata <= '0;
            cmd_own_if   <= 1'b0;
        end else if (!stall) begin
            if (if_gnt) begin
                o_mem_addr <= i_if_addr;
                o_mem_rd   <= 1'b1;
                o_mem_wr   <= 1'b0;
                cmd_own_if <= 1'b1;
            end else if (ls_gnt) begin
                o_mem_addr   <= i_ls_addr;
                o_mem_wrdata <= i_ls_wrdata;
                o_mem_rd     <= i_ls_rd & ~i_ls_wr;
                o_mem_wr     <= i_ls_wr;
                cmd_own_if   <= 1'b0;
            end else begin
                o_mem_rd <= 1'b0;
                o_mem_wr <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_cnt <= '0;
        end else if (!stall) begin
            if (i_if_req & ~if_gnt) begin
                if (starve_cnt != 4'hF)
                    starve_cnt <= starve_cnt + 4'd1;
            end else begin
                starve_cnt <= '0;
            end
        end
    end

    // Owner tags shift every cycle, stalled or not, matching memory latency.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tag_vld <= '0;
            tag_if  <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                tag_vld[i] <= tag_vld[i-1];
                tag_if[i]  <= tag_if[i-1];
            end
            tag_vld[0] <= mem_acc;
            tag_if[0]  <= cmd_own_if;
        end
    end

    assign if_hit = tag_vld[RD_LATENCY-1] & tag_if[RD_LATENCY-1];
    assign ls_hit = tag_vld[RD_LATENCY-1] & ~tag_if[RD_LATENCY-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (if_hit)
                if_rdata_q <= i_mem_rddata;
            if (ls_hit)
                ls_rdata_q <= i_mem_rddata;
        end
    end

    assign o_if_rvalid = if_hit;
    assign o_ls_rvalid = ls_hit;
    assign o_if_rdata  = if_hit ? i_mem_rddata : if_rdata_q;
    assign o_ls_rdata  = ls_hit ? i_mem_rddata : ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: memory responder, queue-based
// reference model checked every cycle, plus directed literal checks.
module tb_mem_port_arbiter;

    localparam int RDL = 1;
    localparam int SL  = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_if_req = 1'b0;
    logic [15:0] i_if_addr = '0;
    logic        o_if_gnt;
    logic        o_if_rvalid;
    logic [15:0] o_if_rdata;
    logic        i_ls_rd = 1'b0;
    logic        i_ls_wr = 1'b0;
    logic [15:0] i_ls_addr = '0;
    logic [15:0] i_ls_wrdata = '0;
    logic        o_ls_gnt;
    logic        o_ls_rvalid;
    logic [15:0] o_ls_rdata;
    logic [15:0] o_mem_addr;
    logic        o_mem_rd;
    logic        o_mem_wr;
    logic [15:0] o_mem_wrdata;
    logic [15:0] i_mem_rddata = '0;
    logic        i_mem_waitreq = 1'b0;
    logic        o_protocol_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(.RD_LATENCY(RDL), .STARVE_LIMIT(SL)) dut (
        .clk           (clk),
        .reset         (reset),
        .i_if_req      (i_if_req),
        .i_if_addr     (i_if_addr),
        .o_if_gnt      (o_if_gnt),
        .o_if_rvalid   (o_if_rvalid),
        .o_if_rdata    (o_if_rdata),
        .i_ls_rd       (i_ls_rd),
        .i_ls_wr       (i_ls_wr),
        .i_ls_addr     (i_ls_addr),
        .i_ls_wrdata   (i_ls_wrdata),
        .o_ls_gnt      (o_ls_gnt),
        .o_ls_rvalid   (o_ls_rvalid),
        .o_ls_rdata    (o_ls_rdata),
        .o_mem_addr    (o_mem_addr),
        .o_mem_rd      (o_mem_rd),
        .o_mem_wr      (o_mem_wr),
        .o_mem_wrdata  (o_mem_wrdata),
        .i_mem_rddata  (i_mem_rddata),
        .i_mem_waitreq (i_mem_waitreq),
        .o_protocol_err(o_protocol_err)
    );

    int ncmp = 0;
    int nerr = 0;
    int cyc  = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s cyc=%0d: got %h expected %h", nm, cyc, act, exp);
        end
    endtask

    logic [15:0] mem [65536];

    typedef struct { bit own_if; int due; logic [15:0] data; } rd_t;
    typedef struct { int due; logic [15:0] data; } rs_t;
    rd_t rq[$];
    rs_t rs[$];

    logic        m_rd = 1'b0, m_wr = 1'b0, m_own_if = 1'b0;
    logic [15:0] m_addr = '0, m_wrdata = '0;
    logic [15:0] m_if_rdata = '0, m_ls_rdata = '0;
    int          m_starve = 0;
    logic [15:0] nxt_rd = '0;

    always @(posedge clk) i_mem_rddata <= nxt_rd;

    always @(negedge clk) begin : model
        logic st, lsr, frc, eif, els, rvi, rvl;
        if (reset) begin
            chk("rst_outs_a", {o_if_gnt, o_ls_gnt, o_if_rvalid, o_ls_rvalid,
                o_mem_rd, o_mem_wr, o_protocol_err, o_mem_addr, o_mem_wrdata}, 0);
            chk("rst_outs_b", {o_if_rdata, o_ls_rdata}, 0);
            rq.delete();
            rs.delete();
            m_rd = 0; m_wr = 0; m_own_if = 0; m_addr = 0; m_wrdata = 0;
            m_if_rdata = 0; m_ls_rdata = 0; m_starve = 0;
        end else begin
            st  = (m_rd | m_wr) & i_mem_waitreq;
            lsr = i_ls_rd | i_ls_wr;
            frc = (m_starve >= SL) && i_if_req;
            eif = !st && (frc || (i_if_req && !lsr));
            els = !st && !eif && lsr;
            rvi = rq.size() > 0 && rq[0].due == cyc && rq[0].own_if;
            rvl = rq.size() > 0 && rq[0].due == cyc && !rq[0].own_if;
            if (rvi) m_if_rdata = rq[0].data;
            if (rvl) m_ls_rdata = rq[0].data;
            chk("if_gnt", o_if_gnt, eif);
            chk("ls_gnt", o_ls_gnt, els);
            chk("perr", o_protocol_err, i_ls_rd & i_ls_wr);
            chk("mem_cmd", {o_mem_rd, o_mem_wr, o_mem_addr, o_mem_wrdata},
                {m_rd, m_wr, m_addr, m_wrdata});
            chk("if_ret", {o_if_rvalid, o_if_rdata}, {rvi, m_if_rdata});
            chk("ls_ret", {o_ls_rvalid, o_ls_rdata}, {rvl, m_ls_rdata});
            if (rvi || rvl) void'(rq.pop_front());
            if (m_rd && !i_mem_waitreq)
                rq.push_back('{m_own_if, cyc + RDL, mem[m_addr]});
            // memory side: responds to what the DUT actually puts on the bus
            if (o_mem_rd && !i_mem_waitreq)
                rs.push_back('{cyc + RDL, mem[o_mem_addr]});
            if (o_mem_wr && !i_mem_waitreq)
                mem[o_mem_addr] = o_mem_wrdata;
            if (!st) begin
                if (eif) begin
                    m_addr = i_if_addr; m_rd = 1; m_wr = 0; m_own_if = 1;
                end else if (els) begin
                    m_addr = i_ls_addr; m_wrdata = i_ls_wrdata;
                    m_wr = i_ls_wr; m_rd = i_ls_rd & ~i_ls_wr; m_own_if = 0;
                end else begin
                    m_rd = 0; m_wr = 0;
                end
                if (i_if_req && !eif)
                    m_starve = (m_starve < 15) ? m_starve + 1 : 15;
                else
                    m_starve = 0;
            end
        end
        if (rs.size() > 0 && rs[0].due == cyc + 1) begin
            nxt_rd = rs[0].data;
            void'(rs.pop_front());
        end else begin
            nxt_rd = 16'h5A5A ^ 16'(cyc);
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic fetch_0010(input string tag);
        tick(); i_if_req = 1; i_if_addr = 16'h0010;
        mid(); chk({tag, "_if_gnt"}, o_if_gnt, 1);
        tick(); i_if_req = 0;
        mid(); chk({tag, "_mem_rd"}, {o_mem_rd, o_mem_addr}, {1'b1, 16'h0010});
        tick();
        mid(); chk({tag, "_rdata"}, {o_if_rvalid, o_if_rdata}, {1'b1, 16'hBEEF});
    endtask

    int cnt;

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'(i) ^ 16'hA5C3;
        mem[16'h0010] = 16'hBEEF;
        repeat (2) mid();
        chk("rst_idle", {o_mem_rd, o_if_gnt, o_ls_gnt, o_if_rvalid}, 0);
        tick(); reset = 0;

        fetch_0010("s1");

        tick(); i_if_req = 1; i_if_addr = 16'h0020;
        i_ls_wr = 1; i_ls_addr = 16'h8000; i_ls_wrdata = 16'h1234;
        mid(); chk("s2_gnt", {o_if_gnt, o_ls_gnt}, 2'b01);
        tick(); i_ls_wr = 0;
        mid();
        chk("s2_write", {o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wrdata},
            {1'b1, 1'b0, 16'h8000, 16'h1234});
        chk("s2_if_next", o_if_gnt, 1);
        tick(); i_if_req = 0;
        mid(); chk("s2_fetch", {o_mem_rd, o_mem_addr}, {1'b1, 16'h0020});
        repeat (2) tick();

        for (int i = 0; i < 7; i++) begin
            tick(); i_ls_rd = 1; i_ls_addr = 16'h0040 + 16'(i);
            i_if_req = (i <= 4); i_if_addr = 16'h0030;
            mid();
            chk("s3_gnt", {o_if_gnt, o_ls_gnt}, (i == 4) ? 2'b10 : 2'b01);
            if (i >= 2)
                chk("s3_owner", {o_if_rvalid, o_ls_rvalid},
                    (i == 6) ? 2'b10 : 2'b01);
        end
        tick(); i_ls_rd = 0; i_if_req = 0;
        repeat (3) tick();

        tick(); i_ls_rd = 1; i_if_req = 1; i_if_addr = 16'h0050;
        i_ls_addr = 16'h00FE;
        mid(); chk("s4_pre1", o_ls_gnt, 1);
        tick(); i_ls_addr = 16'h00FF;
        mid();
        tick(); i_ls_addr = 16'h0100;
        mid(); chk("s4_pre3", {o_if_gnt, o_ls_gnt}, 2'b01);
        tick(); i_ls_addr = 16'h0180; i_mem_waitreq = 1;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) tick();
            mid();
            chk("s4_stall", {o_mem_rd, o_mem_addr, o_if_gnt, o_ls_gnt},
                {1'b1, 16'h0100, 2'b00});
            if (j > 0) chk("s4_no_rv", o_ls_rvalid, 0);
        end
        tick(); i_mem_waitreq = 0;
        mid();
        chk("s4_release", {o_if_gnt, o_ls_gnt}, 2'b01);
        chk("s4_release_rv", o_ls_rvalid, 0);
        tick(); i_ls_addr = 16'h0181;
        mid();
        chk("s4_force", {o_if_gnt, o_ls_gnt}, 2'b10);
        chk("s4_rdata", {o_ls_rvalid, o_ls_rdata}, {1'b1, 16'hA4C3});
        tick(); i_ls_rd = 0; i_if_req = 0;
        repeat (3) tick();

        tick(); i_ls_rd = 1; i_ls_wr = 1; i_ls_addr = 16'h0200;
        i_ls_wrdata = 16'h7777;
        mid(); chk("s5_err", {o_protocol_err, o_ls_gnt}, 2'b11);
        tick(); i_ls_rd = 0; i_ls_wr = 0;
        mid();
        chk("s5_write", {o_mem_wr, o_mem_rd, o_mem_addr, o_mem_wrdata,
            o_protocol_err}, {1'b1, 1'b0, 16'h0200, 16'h7777, 1'b0});
        cnt = 0;
        repeat (3) begin tick(); mid(); cnt += int'(o_ls_rvalid); end
        chk("s5_no_read", cnt, 0);

        tick(); i_if_req = 1; i_if_addr = 16'h0010;
        mid();
        tick(); i_if_req = 0;
        mid(); chk("s6_issue", o_mem_rd, 1);
        tick(); reset = 1;
        #1;
        chk("s6_async", {o_if_rvalid, o_mem_rd, o_mem_addr, o_if_rdata}, 0);
        repeat (2) tick();
        reset = 0;
        cnt = 0;
        repeat (3) begin tick(); mid(); cnt += int'(o_if_rvalid); end
        chk("s6_no_rv", cnt, 0);
        fetch_0010("s6");
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port 16-bit memory between the pipelined CPU's instruction-fetch port and its load/store port.
- Load/store has fixed priority. A starvation counter forces a fetch grant after a bounded number of consecutive fetch denials.
- Registers the memory command, tracks outstanding reads with an owner-tag pipeline, and routes read data back to the correct requester.
- Sits between the CPU core and the memory/interconnect, and supports Avalon-style waitrequest back-pressure.

Parameters:
- RD_LATENCY, 1, cycles from a read command accepted on the memory bus to valid i_mem_rddata (1..4).
- STARVE_LIMIT, 4, consecutive denied fetch-request cycles after which fetch wins the next arbitration (1..15).

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- i_if_req  input  1  fetch read request
- i_if_addr  input  16  fetch address
- o_if_gnt  output  1  fetch request accepted this cycle (combinational)
- o_if_rvalid  output  1  fetch read data valid
- o_if_rdata  output  16  fetch read data
- i_ls_rd  input  1  load request
- i_ls_wr  input  1  store request
- i_ls_addr  input  16  load/store address
- i_ls_wrdata  input  16  store data
- o_ls_gnt  output  1  load/store request accepted this cycle (combinational)
- o_ls_rvalid  output  1  load data valid
- o_ls_rdata  output  16  load data
- o_mem_addr  output  16  memory address (registered)
- o_mem_rd  output  1  memory read strobe (registered)
- o_mem_wr  output  1  memory write strobe (registered)
- o_mem_wrdata  output  16  memory write data (registered)
- i_mem_rddata  input  16  memory read data
- i_mem_waitreq  input  1  memory not accepting the current command
- o_protocol_err  output  1  one-cycle pulse when i_ls_rd and i_ls_wr are both high

Behaviour:

Clocking and reset:
- clk and reset as decided above.
- On reset: every output is 0, the command register is idle, the tag pipeline is cleared, and the starvation counter is 0.
- Reset mid-transaction drops all in-flight reads; no rvalid is produced for them after reset.

Stall condition:
- stall = (o_mem_rd | o_mem_wr) & i_mem_waitreq.
- While stalled: the command register holds, o_if_gnt = o_ls_gnt = 0, and the starvation counter holds.

Arbitration (each non-stalled cycle):
- ls_req = i_ls_rd | i_ls_wr.
- force_if = (starve_cnt >= STARVE_LIMIT) & i_if_req.
- Grant fetch if force_if, or if i_if_req & ~ls_req. Otherwise grant load/store if ls_req.
- At most one gnt is high per cycle.

Command register:
- Loaded on the clock edge following a grant.
  - Fetch grant: addr = i_if_addr, rd = 1.
  - Load/store grant: addr = i_ls_addr, wrdata = i_ls_wrdata, with rd/wr taken from the request.
- No grant and not stalled: rd = wr = 0. addr and wrdata hold.
- Requesters may change inputs in the cycle after their gnt.

Simultaneous i_ls_rd and i_ls_wr:
- The write wins and the read is discarded.
- o_protocol_err pulses high for that cycle.

Starvation counter (4-bit):
- Increments, saturating at 15, each non-stalled cycle in which i_if_req is high and o_if_gnt is low.
- Clears on a fetch grant or when i_if_req is low.

Read return:
- A read command contributes a tag (owner fetch or load/store) on the cycle it is accepted, i.e. o_mem_rd high and i_mem_waitreq low.
- The tag travels through a RD_LATENCY-deep shift register, which also shifts during stalls.
- When the tag emerges, the owner's rvalid is high for exactly 1 cycle and its rdata = i_mem_rddata.
- rdata holds its last value when rvalid is low.
- Writes produce no tag. Responses never reorder.

Throughput and latency:
- One command per cycle when there are no stalls.
- Fetch read, request to o_if_rvalid = 1 + RD_LATENCY cycles minimum.

Test Plan:
1. Reset, idle requests → all outputs 0. Fetch 0x0010 → o_if_gnt the same cycle; next cycle o_mem_rd=1, o_mem_addr=0x0010. With mem returning 0xBEEF at RD_LATENCY=1, o_if_rvalid=1 and o_if_rdata=0xBEEF two cycles after the request.
2. Simultaneous i_if_req(0x0020) and i_ls_wr(addr 0x8000, data 0x1234) → o_ls_gnt=1 and o_if_gnt=0. Next cycle o_mem_wr=1, addr 0x8000, data 0x1234. The fetch is granted the following cycle.
3. Continuous load/store reads plus continuous fetch, STARVE_LIMIT=4 → fetch denied 4 cycles, granted on the 5th cycle, then load/store resumes. Check the rvalid sequence matches grant order with correct owners.
4. i_mem_waitreq held high 3 cycles on a pending read of 0x0100 → o_mem_* stable, no grants, counter frozen. On release, exactly one tag is recorded and a single rvalid follows.
5. i_ls_rd=i_ls_wr=1 at 0x0200 → one write issued, no read, o_protocol_err pulses once.
6. Reset asserted one cycle after a fetch read is issued → no o_if_rvalid afterwards. Outputs are 0 immediately (async) and the first post-reset grant behaves as in scenario 1.
